// File: rtl/laser310_pkg.sv
// Shared types and constants for the Laser 310 tape upload path (VZ file format).
package laser310_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READY   = 2'd2,
        ST_UPLOAD  = 2'd3
    } vz_state_e;

    localparam int          VZ_HDR_LEN    = 24;
    localparam logic [31:0] VZ_MAGIC      = 32'h565A_4630;   // "VZF0", first byte in MSBs
    localparam logic [47:0] VZ_NAME       = "MISTER";
    localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
    localparam logic [7:0]  VZ_TYPE_BIN   = 8'hF1;

    // Header layout: magic[0..3], name[4..20] zero padded, type[21], start addr LE[22..23].
    function automatic logic [7:0] vz_hdr_byte(input logic [4:0]  idx,
                                               input logic [7:0]  ftype,
                                               input logic [15:0] start);
        logic [7:0] b;
        b = 8'h00;
        if (idx < 5'd4)
            b = VZ_MAGIC[8*(3 - int'(idx)) +: 8];
        else if (idx < 5'd10)
            b = VZ_NAME[8*(9 - int'(idx)) +: 8];
        else if (idx == 5'd21)
            b = ftype;
        else if (idx == 5'd22)
            b = start[7:0];
        else if (idx == 5'd23)
            b = start[15:8];
        return b;
    endfunction

endpackage

// File: rtl/vz_tape_upload_if.sv
// Capture stream, hps_io upload port and status outputs of vz_tape_upload.
interface vz_tape_upload_if #(
    parameter int ADDR_W = 14
);
    logic              cap_begin;
    logic              cap_valid;
    logic [7:0]        cap_data;
    logic              cap_end;
    logic [7:0]        cap_type;
    logic [15:0]       cap_start_addr;

    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_din;

    logic [ADDR_W-1:0] file_size;
    logic              ready;
    logic              overflow;
    logic              busy;

    modport master (
        output cap_begin, cap_valid, cap_data, cap_end, cap_type, cap_start_addr,
        output ioctl_upload, ioctl_rd, ioctl_addr,
        input  ioctl_din, file_size, ready, overflow, busy
    );

    modport slave (
        input  cap_begin, cap_valid, cap_data, cap_end, cap_type, cap_start_addr,
        input  ioctl_upload, ioctl_rd, ioctl_addr,
        output ioctl_din, file_size, ready, overflow, busy
    );
endinterface

// File: rtl/vz_tape_buf.sv
// Capture buffer: DEPTH x 8 simple dual-port RAM, one write port, registered read port.
module vz_tape_buf #(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_sys,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // No reset so the array maps onto block RAM; the read register holds when re_i is low.
    always_ff @(posedge clk_sys) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
        if (re_i)
            rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/vz_tape_upload.sv
// Captures a Laser 310 tape save and serves it to the HPS as a VZ file over ioctl upload.
// Build option VZ_HEADER_EN prepends the 24-byte VZ header; otherwise the raw payload is served.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | nothing captured since reset
// ST_CAPTURE | save in progress, bytes go into the buffer
// ST_READY   | complete capture held, waiting for an upload
// ST_UPLOAD  | HPS is reading the file
module vz_tape_upload
    import laser310_pkg::*;
#(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 14
) (
    input  logic           clk_sys,
    input  logic           reset,
    vz_tape_upload_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int SUM_W = ((ADDR_W > PTR_W) ? ADDR_W : PTR_W) + 1;
`ifdef VZ_HEADER_EN
    localparam int HDR = VZ_HDR_LEN;
`else
    localparam int HDR = 0;
`endif
    localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(DEPTH);
    localparam logic [SUM_W-1:0]  FS_MAX   = SUM_W'((1 << ADDR_W) - 1);
    localparam logic [SUM_W-1:0]  HDR_S    = SUM_W'(HDR);
    localparam logic [ADDR_W-1:0] HDR_A    = ADDR_W'(HDR);

    vz_state_e         state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              overflow_q, overflow_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] file_size_q, file_size_d;
    logic              src_buf_q, src_buf_d;
    logic [7:0]        byte_q, byte_d;
    logic              upload_q;

    logic              begin_evt;
    logic              upl_rise;
    logic              upl_fall;
    logic              buf_we;
    logic              buf_re;
    logic [7:0]        buf_rdata;
    logic [SUM_W-1:0]  fsum;
    logic              hdr_hit;
    logic [7:0]        hdr_data;

    assign begin_evt = bus.cap_begin && (state_q != ST_UPLOAD);
    assign upl_rise  = bus.ioctl_upload && !upload_q;
    assign upl_fall  = !bus.ioctl_upload && upload_q;

`ifdef VZ_HEADER_EN
    logic [7:0]  type_q;
    logic [15:0] start_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            type_q  <= 8'h00;
            start_q <= 16'h0000;
        end else if (begin_evt) begin
            type_q  <= bus.cap_type;
            start_q <= bus.cap_start_addr;
        end
    end

    assign hdr_hit  = bus.ioctl_addr < HDR_A;
    assign hdr_data = vz_hdr_byte(bus.ioctl_addr[4:0], type_q, start_q);
`else
    logic unused_hdr;
    assign unused_hdr = ^{bus.cap_type, bus.cap_start_addr};
    assign hdr_hit    = 1'b0;
    assign hdr_data   = 8'h00;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            ready_q     <= 1'b0;
            file_size_q <= '0;
            src_buf_q   <= 1'b0;
            byte_q      <= 8'h00;
            upload_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            overflow_q  <= overflow_d;
            ready_q     <= ready_d;
            file_size_q <= file_size_d;
            src_buf_q   <= src_buf_d;
            byte_q      <= byte_d;
            upload_q    <= bus.ioctl_upload;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        overflow_d  = overflow_q;
        ready_d     = ready_q;
        file_size_d = file_size_q;
        src_buf_d   = src_buf_q;
        byte_d      = byte_q;
        buf_we      = 1'b0;
        buf_re      = 1'b0;
        fsum        = '0;

        // A new save restarts capture from any state except UPLOAD; same-cycle bytes are dropped.
        if (begin_evt) begin
            state_d    = ST_CAPTURE;
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
            ready_d    = 1'b0;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (bus.cap_valid) begin
                        if (wr_ptr_q < PTR_FULL) begin
                            buf_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (bus.cap_end) begin
                        fsum    = HDR_S + SUM_W'(wr_ptr_d);
                        state_d = ST_READY;
                        ready_d = 1'b1;
                        file_size_d = (fsum > FS_MAX) ? {ADDR_W{1'b1}} : ADDR_W'(fsum);
                    end
                end
                ST_READY: begin
                    if (upl_rise)
                        state_d = ST_UPLOAD;
                end
                ST_UPLOAD: begin
                    if (upl_fall)
                        state_d = ST_READY;
                    if (bus.ioctl_rd) begin
                        if (hdr_hit) begin
                            src_buf_d = 1'b0;
                            byte_d    = hdr_data;
                        end else if (bus.ioctl_addr < file_size_q) begin
                            src_buf_d = 1'b1;
                            buf_re    = 1'b1;
                        end else begin
                            src_buf_d = 1'b0;
                            byte_d    = 8'h00;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    vz_tape_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_sys (clk_sys),
        .we_i    (buf_we),
        .waddr_i (AW'(wr_ptr_q)),
        .wdata_i (bus.cap_data),
        .re_i    (buf_re),
        .raddr_i (AW'(bus.ioctl_addr - HDR_A)),
        .rdata_o (buf_rdata)
    );

    // The RAM output register doubles as the read-data register for payload bytes.
    assign bus.ioctl_din = src_buf_q ? buf_rdata : byte_q;
    assign bus.file_size = file_size_q;
    assign bus.ready     = ready_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state_q == ST_CAPTURE) || (state_q == ST_UPLOAD);
endmodule

// File: tb/tb_vz_tape_upload.sv
// Directed bench for vz_tape_upload with a small DEPTH; read data is checked through a byte scoreboard.
module tb_vz_tape_upload;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 14;
`ifdef VZ_HEADER_EN
    localparam int HDR = 24;
`else
    localparam int HDR = 0;
`endif

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    vz_tape_upload_if #(.ADDR_W(ADDR_W)) bus ();

    vz_tape_upload #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #50 clk_sys = ~clk_sys;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  stim_q[$];
    logic [7:0]  m_pay[$];
    logic [7:0]  m_type;
    logic [15:0] m_start;
    bit          m_ready;
    bit          m_ovf;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hdr_model(input int a);
        case (a)
            0:  return 8'h56;
            1:  return 8'h5A;
            2:  return 8'h46;
            3:  return 8'h30;
            4:  return 8'h4D;
            5:  return 8'h49;
            6:  return 8'h53;
            7:  return 8'h54;
            8:  return 8'h45;
            9:  return 8'h52;
            21: return m_type;
            22: return m_start[7:0];
            23: return m_start[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] model_byte(input int a);
        if (!m_ready) return 8'h00;
        if (a < HDR) return hdr_model(a);
        if (a < HDR + m_pay.size()) return m_pay[a - HDR];
        return 8'h00;
    endfunction

    task automatic capture(input logic [7:0] ftype, input logic [15:0] start,
                           input bit junk, input bit end_with_valid);
        bus.cap_type       = ftype;
        bus.cap_start_addr = start;
        bus.cap_begin      = 1'b1;
        bus.cap_valid      = junk;
        bus.cap_data       = 8'hEE;
        tick();
        bus.cap_begin      = 1'b0;
        bus.cap_valid      = 1'b0;
        bus.cap_type       = 8'h00;
        bus.cap_start_addr = 16'h0000;
        m_type  = ftype;
        m_start = start;
        m_pay.delete();
        m_ready = 1'b0;
        m_ovf   = 1'b0;
        chk("cap_busy", 32'(bus.busy), 32'd1);
        chk("cap_ready_clr", 32'(bus.ready), 32'd0);
        chk("cap_ovf_clr", 32'(bus.overflow), 32'd0);
        foreach (stim_q[i]) begin
            bus.cap_valid = 1'b1;
            bus.cap_data  = stim_q[i];
            bus.cap_end   = end_with_valid && (i == stim_q.size() - 1);
            tick();
            if (m_pay.size() < DEPTH) m_pay.push_back(stim_q[i]);
            else m_ovf = 1'b1;
        end
        bus.cap_valid = 1'b0;
        if (!bus.cap_end) begin
            bus.cap_end = 1'b1;
            tick();
        end
        bus.cap_end = 1'b0;
        m_ready = 1'b1;
        chk("end_ready", 32'(bus.ready), 32'd1);
        chk("end_file_size", 32'(bus.file_size), 32'(HDR + m_pay.size()));
        chk("end_overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("end_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic upload_begin(input bit exp_busy);
        bus.ioctl_upload = 1'b1;
        tick();
        tick();
        chk("upl_busy", 32'(bus.busy), 32'(exp_busy));
    endtask

    task automatic upload_end();
        bus.ioctl_upload = 1'b0;
        tick();
        tick();
        chk("upl_end_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic upload_read(input int first, input int n);
        logic [7:0] last;
        last = 8'h00;
        for (int a = first; a < first + n; a++) begin
            bus.ioctl_addr = ADDR_W'(a);
            bus.ioctl_rd   = 1'b1;
            sb_q.push_back(model_byte(a));
            tick();
            last = sb_q.pop_front();
            chk($sformatf("din[%0d]", a), 32'(bus.ioctl_din), 32'(last));
        end
        bus.ioctl_rd   = 1'b0;
        bus.ioctl_addr = ADDR_W'(first + 1);
        tick();
        tick();
        chk("din_hold", 32'(bus.ioctl_din), 32'(last));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cap_begin      = 1'b0;
        bus.cap_valid      = 1'b0;
        bus.cap_data       = 8'h00;
        bus.cap_end        = 1'b0;
        bus.cap_type       = 8'h00;
        bus.cap_start_addr = 16'h0000;
        bus.ioctl_upload   = 1'b0;
        bus.ioctl_rd       = 1'b0;
        bus.ioctl_addr     = '0;
        m_ready = 1'b0;
        m_ovf   = 1'b0;
        m_type  = 8'h00;
        m_start = 16'h0000;

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_file_size", 32'(bus.file_size), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_din", 32'(bus.ioctl_din), 32'd0);
        reset = 1'b0;
        tick();

        // cap_end outside CAPTURE does nothing
        bus.cap_end = 1'b1;
        tick();
        bus.cap_end = 1'b0;
        tick();
        chk("idle_end_ready", 32'(bus.ready), 32'd0);
        chk("idle_end_busy", 32'(bus.busy), 32'd0);

        // basic BASIC save, three bytes
        stim_q = '{8'h11, 8'h22, 8'h33};
        capture(8'hF0, 16'h7AE9, 1'b0, 1'b0);
        upload_begin(1'b1);
        upload_read(0, HDR + 4);
        upload_end();
        chk("after_upl_ready", 32'(bus.ready), 32'd1);

        // cap_begin+cap_valid drops the byte; cap_valid+cap_end keeps it
        stim_q = '{8'h01, 8'h02, 8'h03};
        capture(8'hF1, 16'h8000, 1'b1, 1'b1);
        upload_begin(1'b1);
        upload_read(0, HDR + 4);

        // cap_begin during UPLOAD is ignored
        bus.cap_begin = 1'b1;
        bus.cap_valid = 1'b1;
        bus.cap_data  = 8'hAB;
        tick();
        bus.cap_begin = 1'b0;
        bus.cap_valid = 1'b0;
        chk("upl_begin_busy", 32'(bus.busy), 32'd1);
        upload_end();
        chk("upl_begin_ready", 32'(bus.ready), 32'd1);
        chk("upl_begin_fsize", 32'(bus.file_size), 32'(HDR + 3));
        upload_begin(1'b1);
        upload_read(0, HDR + 4);
        upload_end();

        // overflow: 20 bytes into a 16-byte buffer
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(8'(8'h40 + i));
        capture(8'hF1, 16'hC000, 1'b0, 1'b0);
        upload_begin(1'b1);
        upload_read(0, HDR + DEPTH + 3);
        upload_end();

        // reset in the middle of an upload
        stim_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        capture(8'hF0, 16'h1234, 1'b0, 1'b0);
        upload_begin(1'b1);
        upload_read(0, 5);
        bus.ioctl_addr = ADDR_W'(HDR + 1);
        bus.ioctl_rd   = 1'b1;
        reset = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        chk("mid_rst_ready", 32'(bus.ready), 32'd0);
        chk("mid_rst_fsize", 32'(bus.file_size), 32'd0);
        chk("mid_rst_din", 32'(bus.ioctl_din), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        m_ready = 1'b0;
        m_pay.delete();
        upload_end();
        upload_begin(1'b0);
        upload_read(0, HDR + 6);
        upload_end();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
